// File: rtl/seven_seg_mux_n.sv
// Multiplexed driver for an N-digit common-anode 7-segment display with
// double-buffered data, PWM brightness, leading-zero suppression and blink.
module seven_seg_mux_n #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 150000,
    parameter int unsigned BRIGHT_W     = 3,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic [NUM_DIGITS-1:0]     i_blink,
    input  logic                      i_load,
    input  logic                      i_lz_suppress,
    input  logic [BRIGHT_W-1:0]       i_brightness,
    output logic [NUM_DIGITS-1:0]     o_digits,
    output logic [7:0]                o_segments,
    output logic                      o_frame_done
);

    localparam int unsigned SLOT_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [FRAME_W-1:0]      r_frame_cnt;
    logic                    r_blink_phase;
    logic [4*NUM_DIGITS-1:0] r_shd_value, r_act_value;
    logic [NUM_DIGITS-1:0]   r_shd_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_shd_blink, r_act_blink;
    logic [NUM_DIGITS-1:0]   r_digits;
    logic [7:0]              r_segments;
    logic                    r_frame_done;

    logic                    w_slot_last;
    logic                    w_frame_end;
    logic [3:0]              w_nibble;
    logic                    w_cur_dp;
    logic                    w_cur_blink;
    logic                    w_cur_lz;
    logic                    w_lz_run;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_lit;
    logic [6:0]              w_glyph;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_slot_last = (r_slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign w_frame_end = w_slot_last && (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_onehot    = NUM_DIGITS'(1) << r_digit_idx;

    // Select the current digit's data and its leading-zero status
    always_comb begin
        w_nibble    = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blink = 1'b0;
        w_cur_lz    = 1'b0;
        w_lz_run    = 1'b1;
        w_lz_blank  = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run      = w_lz_run && (r_act_value[i*4 +: 4] == 4'h0) && !r_act_dp[i];
            w_lz_blank[i] = w_lz_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble    = r_act_value[i*4 +: 4];
                w_cur_dp    = r_act_dp[i];
                w_cur_blink = r_act_blink[i];
                w_cur_lz    = w_lz_blank[i];
            end
        end
    end

    // Hex glyphs, active-high {G,F,E,D,C,B,A}
    always_comb begin
        w_glyph = 7'h00;
        case (w_nibble)
            4'h0: w_glyph = 7'h3F;
            4'h1: w_glyph = 7'h06;
            4'h2: w_glyph = 7'h5B;
            4'h3: w_glyph = 7'h4F;
            4'h4: w_glyph = 7'h66;
            4'h5: w_glyph = 7'h6D;
            4'h6: w_glyph = 7'h7D;
            4'h7: w_glyph = 7'h07;
            4'h8: w_glyph = 7'h7F;
            4'h9: w_glyph = 7'h6F;
            4'hA: w_glyph = 7'h77;
            4'hB: w_glyph = 7'h7C;
            4'hC: w_glyph = 7'h39;
            4'hD: w_glyph = 7'h5E;
            4'hE: w_glyph = 7'h79;
            4'hF: w_glyph = 7'h71;
            default: w_glyph = 7'h00;
        endcase
    end

    // Slot 0 is always dark so the previous digit's segments never ghost
    assign w_lit = (r_slot_cnt != '0)
                && (r_slot_cnt[BRIGHT_W-1:0] <= i_brightness)
                && !(i_lz_suppress && w_cur_lz)
                && !(r_blink_phase && w_cur_blink);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_shd_value   <= '0;
            r_shd_dp      <= '0;
            r_shd_blink   <= '0;
            r_act_value   <= '0;
            r_act_dp      <= '0;
            r_act_blink   <= '0;
            r_digits      <= '1;
            r_segments    <= 8'hFF;
            r_frame_done  <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_last ? '0 : r_slot_cnt + SLOT_W'(1);
            r_frame_done <= w_frame_end;
            if (w_slot_last) begin
                r_digit_idx <= w_frame_end ? '0 : r_digit_idx + IDX_W'(1);
            end
            // Active takes the pre-edge shadow, so a coincident load waits a frame
            if (w_frame_end) begin
                r_act_value <= r_shd_value;
                r_act_dp    <= r_shd_dp;
                r_act_blink <= r_shd_blink;
                if (r_frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= !r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                end
            end
            if (i_load) begin
                r_shd_value <= i_value;
                r_shd_dp    <= i_dp;
                r_shd_blink <= i_blink;
            end
            r_digits   <= w_lit ? ~w_onehot : '1;
            r_segments <= w_lit ? {~w_cur_dp, ~w_glyph} : 8'hFF;
        end
    end

    assign o_digits     = r_digits;
    assign o_segments   = r_segments;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Randomised scoreboard bench for seven_seg_mux_n against a cycle-count based
// reference model of the display schedule.
module tb_seven_seg_mux_n;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BW = 3;
    localparam int BF = 2;
    localparam int FRAME_CYC = ND * RD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    blink = '0;
    logic          load = 1'b0;
    logic          lz = 1'b0;
    logic [BW-1:0] bright = '1;
    logic [3:0]    digits;
    logic [7:0]    segments;
    logic          frame_done;

    seven_seg_mux_n #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp(dp), .i_blink(blink),
        .i_load(load), .i_lz_suppress(lz), .i_brightness(bright),
        .o_digits(digits), .o_segments(segments), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        bit         seg_chk;
        bit         fd;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Lit segments of each hex glyph, bit0 = A ... bit6 = G
    logic [6:0] glyph_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int         c = 0;
    logic [15:0] sh_val = '0, ac_val = '0;
    logic [3:0]  sh_dp = '0, ac_dp = '0, sh_bl = '0, ac_bl = '0;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Predict the outputs produced by the coming edge, then advance the model
    task automatic tick();
        exp_t e;
        int   s, idx, frame;
        bit   phase, supp, lit;
        if (rst) begin
            e = '{dig: 4'hF, seg: 8'hFF, seg_chk: 1'b1, fd: 1'b0};
            c = 0;
            sh_val = '0; ac_val = '0; sh_dp = '0; ac_dp = '0; sh_bl = '0; ac_bl = '0;
        end else begin
            s     = c % RD;
            idx   = (c / RD) % ND;
            frame = c / FRAME_CYC;
            phase = ((frame / BF) % 2) == 1;
            supp  = 1'b0;
            if (lz && idx > 0) begin
                supp = 1'b1;
                for (int j = idx; j < ND; j++)
                    if (ac_val[j*4 +: 4] != 4'h0 || ac_dp[j]) supp = 1'b0;
            end
            lit = (s != 0) && ((s % (1 << BW)) <= int'(bright)) && !supp && !(phase && ac_bl[idx]);
            e.fd      = (c % FRAME_CYC) == FRAME_CYC - 1;
            e.seg_chk = (s != 0);
            e.dig     = lit ? 4'(~(1 << idx)) : 4'hF;
            e.seg     = lit ? {~ac_dp[idx], ~glyph_on[ac_val[idx*4 +: 4]]} : 8'hFF;
            if (e.fd) begin
                ac_val = sh_val; ac_dp = sh_dp; ac_bl = sh_bl;
            end
            if (load) begin
                sh_val = value; sh_dp = dp; sh_bl = blink;
            end
            c++;
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < FRAME_CYC && (c % FRAME_CYC) != pos; k++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp = d; blink = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Monitor: every edge yields one output word to score
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("digits", int'(digits), int'(e.dig));
                check("frame_done", int'(frame_done), int'(e.fd));
                if (e.seg_chk) check("segments", int'(segments), int'(e.seg));
                check("one_low", $countones(~digits) <= 1, 1);
            end
        end
    end

    initial begin
        @(negedge clk);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        bright = 3'd7;
        do_load(16'h12AF, 4'h0, 4'h0);
        run(100);
        run_to(10);
        do_load(16'h1234, 4'h0, 4'h0);
        run(5);
        do_load(16'h5678, 4'h2, 4'h0);
        run_to(FRAME_CYC - 1);
        do_load(16'h9ABC, 4'h0, 4'h0);
        run(70);
        lz = 1'b1;
        do_load(16'h0050, 4'h0, 4'h0);
        run(70);
        do_load(16'h0050, 4'h8, 4'h0);
        run(70);
        bright = 3'd0;
        run(40);
        bright = 3'd3;
        run(40);
        bright = 3'd7;
        lz = 1'b0;
        do_load(16'h8888, 4'h0, 4'h1);
        run(200);
        run_to(12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(70);
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                value = 16'($urandom) & (($urandom_range(0, 1) == 1) ? 16'h00FF : 16'hFFFF);
                dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                blink = 4'($urandom);
                load  = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) bright = BW'($urandom);
            if ($urandom_range(0, 36) == 0) lz = ~lz;
            rst = ($urandom_range(0, 399) == 0);
            tick();
            load = 1'b0;
            rst  = 1'b0;
        end
        @(posedge clk);
        #2;
        check("queue_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux_n.md
Name: seven_seg_mux_n

Overview:
Parametrised multiplexed driver for an N-digit common-anode 7-segment display.
- Cycles through the digits with a programmable slot time.
- Decodes hex nibbles to segments, with per-digit decimal point.
- Adds PWM brightness, leading-zero suppression and per-digit blink.
- Display data is double-buffered: a load never tears a frame.
- Sits between application logic and the board's digit/segment pins.

Parameters:
NUM_DIGITS, 4, number of digits multiplexed (>=2)
REFRESH_DIV, 150000, clk cycles per digit slot (>=2^BRIGHT_W)
BRIGHT_W, 3, brightness control width; 2^BRIGHT_W PWM steps
BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 is rightmost)
dp  in  NUM_DIGITS  decimal point request per digit
blink  in  NUM_DIGITS  blink enable per digit
load  in  1  one-cycle strobe; captures value/dp/blink into the shadow register
lz_suppress  in  1  blank leading zero digits
brightness  in  BRIGHT_W  0 = dimmest (1/2^BRIGHT_W duty), all-ones = full on
digits  out  NUM_DIGITS  digit enables, active-low, one-hot-low when lit
segments  out  8  {DP,G,F,E,D,C,B,A}, active-low
frame_done  out  1  one-cycle pulse after the last digit slot of each frame

Behaviour:
- Reset values:
  - digits all 1, segments 8'hFF, frame_done 0.
  - Shadow and active registers 0; slot counter 0, digit index 0, blink phase 0, frame counter 0.
- Slot timer:
  - slot_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the digit index increments.
  - The index wraps from NUM_DIGITS-1 to 0.
- Frame boundary (index wraps to 0):
  - active <= shadow.
  - frame_done = 1 for exactly that cycle.
  - Frame counter increments; at BLINK_FRAMES-1 it wraps and the blink phase toggles.
- Load:
  - load=1 captures the inputs into shadow on that edge.
  - The displayed data changes only at the next frame boundary.
  - A load coinciding with a frame boundary: the old shadow goes to active this boundary; the new data appears at the following boundary.
  - Multiple loads in one frame: last wins.
- Decode: nibbles 0-F map to standard hex glyphs (b and d lowercase). segments[7] = ~dp[i].
- Leading-zero suppression: with lz_suppress=1, digit i>0 is blanked when nibbles NUM_DIGITS-1..i are all 0 and dp is 0 for all of them. Digit 0 is never suppressed.
- PWM: the current digit's enable is driven low only while slot_cnt[BRIGHT_W-1:0] <= brightness. Otherwise digits are all 1.
- Blink: when blink phase=1, digits with active blink bit set are blanked.
- Blank handling:
  - A blanked digit (suppression, blink, or PWM off-phase) drives digits all 1 and segments 8'hFF.
  - Anti-ghost: in slot_cnt==0 of every slot, digits are all 1.
- Latency:
  - digits and segments are registered, 1 cycle after the counter state they reflect.
  - At most one digits bit is low in any cycle.
- Inputs: brightness and lz_suppress are sampled live; a change takes effect within 1 cycle.
- Reset mid-frame: all outputs return to reset values on the next edge, and the shadow is cleared.

Test Plan:
(Bench parameters: REFRESH_DIV=8, BRIGHT_W=3, NUM_DIGITS=4, BLINK_FRAMES=2.)

1. Reset then load value=16'h12AF, dp=0, brightness=7.
   - After the first frame boundary, slots show digit0 segments=8'b10001110 (F), digit1 8'b10001000 (A), digit2 8'b10100100 (2), digit3 8'b11111001 (1).
   - digits cycles 1110,1101,1011,0111, each low for 7 of 8 cycles.
   - frame_done pulses every 32 cycles.
2. Load 16'h1234 mid-frame.
   - The current frame keeps the old data; the new data appears only after the next frame_done.
   - A second load in the same frame overrides the first.
3. lz_suppress=1, value=16'h0050, dp=0.
   - Digits 3 and 2 stay blank (digits bit high, segments FF).
   - Digit 1 shows 5, digit 0 shows 0.
   - Repeat with dp[3]=1: digit 3 shows 0 with DP lit (segments 8'b01000000).
4. brightness=0: each digit is lit only at slot_cnt 0 -> blocked by anti-ghost, so digit is lit 0 cycles. brightness=3: lit slot_cnt 1..3 (3 cycles).
5. blink=4'b0001, value=16'h8888.
   - Digit 0 is lit for 2 frames and blank for 2 frames, alternately.
   - Other digits are lit continuously.
6. Assert rst for one cycle mid-slot.
   - Next edge: digits=4'b1111, segments=8'hFF, frame_done=0.
   - With no new load, the display stays blank-patterned as 0 (lz_suppress=0 shows "0000" after the first frame).
